dmem_buffered: RTL and testbench

Parametrised data-memory stage of the pipelined core with a posted-store buffer. Stores are queued in a small FIFO and drained to a single-port-write synchronous RAM one per cycle. Loads are answered one cycle later, with store-to-load forwarding from the queue. It sits between the execute stage (address/data already resolved, forwarding muxes upstream) and write-back.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_buffered_if.sv | 29 ++
 rtl/dmem_store_buffer.sv | 95 +++++++++
 rtl/dmem_buffered.sv | 100 ++++++++++
 tb/tb_dmem_buffered.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the buffered data-memory stage.
package dmem_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 8;
    localparam int SB_DEPTH_DEF = 4;

    // One posted store at the default word/address widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;

    // Pointer width for a power-of-two store buffer of the given depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_buffered_if.sv
// Request/response bundle between the execute stage (master) and the data-memory stage (slave).
interface dmem_buffered_if
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SB_DEPTH = SB_DEPTH_DEF
);
    logic                           flush;
    logic                           mem_read;
    logic                           mem_write;
    logic [ADDR_W-1:0]              addr;
    logic [DATA_W-1:0]              wdata;
    logic [DATA_W-1:0]              rdata;
    logic                           rdata_valid;
    logic                           stall;
    logic [$clog2(SB_DEPTH):0]      sb_count;

    modport master (
        output flush, mem_read, mem_write, addr, wdata,
        input  rdata, rdata_valid, stall, sb_count
    );

    modport slave (
        input  flush, mem_read, mem_write, addr, wdata,
        output rdata, rdata_valid, stall, sb_count
    );

endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO with youngest-match address search; head drains every cycle it is non-empty.
// Latency: pushed entry visible to lookup and drain the cycle after push.
// Backpressure: none internally; caller must not push while count == SB_DEPTH.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int ADDR_W   = ADDR_W_DEF,
    parameter  int SB_DEPTH = SB_DEPTH_DEF,
    localparam int PTR_W    = ptr_w(SB_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_vld,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_dat,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
`ifdef DMEM_FWD_EN
    output logic [DATA_W-1:0] hit_dat,
`endif
    output logic              drain_vld,
    output logic [ADDR_W-1:0] drain_addr,
    output logic [DATA_W-1:0] drain_dat,
    output logic [CNT_W-1:0]  count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t             slot_q [SB_DEPTH];
    slot_t             slot_d [SB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  idx;

    assign drain_vld  = (count_q != '0);
    assign drain_addr = slot_q[head_q].addr;
    assign drain_dat  = slot_q[head_q].data;
    assign count      = count_q;

    always_comb begin
        slot_d  = slot_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push_vld) begin
            slot_d[tail_q] = '{addr: push_addr, data: push_dat};
            tail_d         = tail_q + 1'b1;
        end
        if (drain_vld) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_vld) - CNT_W'(drain_vld);
    end

    // Walk oldest to youngest so the last match (youngest) wins; the head is
    // included even though it drains this edge, since the RAM read sees old data.
    always_comb begin
        hit = 1'b0;
`ifdef DMEM_FWD_EN
        hit_dat = '0;
`endif
        idx = head_q;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (slot_q[idx].addr == lookup_addr)) begin
                hit = 1'b1;
`ifdef DMEM_FWD_EN
                hit_dat = slot_q[idx].data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/dmem_buffered.sv
// Data-memory stage: posted stores drain to RAM one per cycle; DMEM_FWD_EN enables store-to-load forwarding.
// Latency: load result registered one cycle after acceptance; stores reach RAM the cycle after they are at the head.
// Backpressure: stall on store into a full buffer; without DMEM_FWD_EN also on a load hitting a pending store.
module dmem_buffered
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    dmem_buffered_if.slave bus
);

    localparam int CNT_W = ptr_w(SB_DEPTH) + 1;

    logic              sb_hit;
`ifdef DMEM_FWD_EN
    logic [DATA_W-1:0] sb_hit_dat;
`endif
    logic              drain_vld;
    logic [ADDR_W-1:0] drain_addr;
    logic [DATA_W-1:0] drain_dat;
    logic [CNT_W-1:0]  sb_count;

    logic [DATA_W-1:0] ram_q [2**ADDR_W];
    logic [DATA_W-1:0] ram_rd;
    logic              full;
    logic              stall;
    logic              push_vld;
    logic              load_acc;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;

    dmem_store_buffer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .push_vld    (push_vld),
        .push_addr   (bus.addr),
        .push_dat    (bus.wdata),
        .lookup_addr (bus.addr),
        .hit         (sb_hit),
`ifdef DMEM_FWD_EN
        .hit_dat     (sb_hit_dat),
`endif
        .drain_vld   (drain_vld),
        .drain_addr  (drain_addr),
        .drain_dat   (drain_dat),
        .count       (sb_count)
    );

    // A read paired with a write is dropped, so only a pure load can stall on a hit.
    always_comb begin
        full  = (sb_count == CNT_W'(SB_DEPTH));
        stall = bus.mem_write & full;
`ifndef DMEM_FWD_EN
        stall = stall | (bus.mem_read & ~bus.mem_write & sb_hit);
`endif
        push_vld      = bus.mem_write & ~bus.flush & ~stall;
        load_acc      = bus.mem_read & ~bus.mem_write & ~bus.flush & ~stall;
        ram_rd        = ram_q[bus.addr];
        rdata_valid_d = load_acc;
        rdata_d       = rdata_q;
        if (load_acc) begin
`ifdef DMEM_FWD_EN
            rdata_d = sb_hit ? sb_hit_dat : ram_rd;
`else
            rdata_d = ram_rd;
`endif
        end
    end

    // Reset discards the queued stores, including the head that would drain this edge.
    always_ff @(posedge clk) begin
        if (!reset && drain_vld) begin
            ram_q[drain_addr] <= drain_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.sb_count    = sb_count;

endmodule

// File: tb/tb_dmem_buffered.sv
// Directed plus random traffic against a queue/array model of the buffered data-memory stage.
module tb_dmem_buffered;
    import dmem_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int SBD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_buffered_if #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(SBD)) bus ();

    dmem_buffered #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(SBD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sb_entry_t   mq [$];
    logic [7:0]  mmem [256];
    logic [7:0]  exp_rdata;
    logic        exp_valid;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);
        mq.delete();
        exp_rdata = 8'h00;
        exp_valid = 1'b0;
        #1;
        chk("reset_sb_count", bus.sb_count, 0);
        chk("reset_rdata", bus.rdata, exp_rdata);
        chk("reset_rdata_valid", bus.rdata_valid, exp_valid);
    endtask

    // One clock of traffic: predict stall and load result from the model, then retire drain/push.
    task automatic step(input logic rd, input logic wr, input logic fl,
                        input logic [7:0] a, input logic [7:0] d, output logic stalled);
        logic       hit;
        logic [7:0] hd;
        logic       exp_stall;
        logic       ld;
        sb_entry_t  e;
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.flush     = fl;
        bus.addr      = a;
        bus.wdata     = d;
        hit = 1'b0;
        hd  = mmem[a];
        foreach (mq[i]) begin
            if (mq[i].addr == a) begin
                hit = 1'b1;
                hd  = mq[i].data;
            end
        end
        exp_stall = wr && (mq.size() == SBD);
`ifndef DMEM_FWD_EN
        if (rd && !wr && hit) exp_stall = 1'b1;
`endif
        #1;
        chk("stall", bus.stall, exp_stall);
        ld = rd && !wr && !fl && !exp_stall;
        if (ld) exp_rdata = hd;
        exp_valid = ld;
        @(posedge clk);
        if (mq.size() > 0) begin
            e = mq.pop_front();
            mmem[e.addr] = e.data;
        end
        if (wr && !fl && !exp_stall) begin
            e = '{addr: a, data: d};
            mq.push_back(e);
        end
        #1;
        chk("rdata_valid", bus.rdata_valid, exp_valid);
        chk("rdata", bus.rdata, exp_rdata);
        chk("sb_count", bus.sb_count, mq.size());
        stalled = exp_stall;
    endtask

    // Present a load and hold it while stalled, as upstream would.
    task automatic load_hold(input logic [7:0] a);
        logic s;
        s = 1'b1;
        for (int n = 0; n < 8 && s; n++) begin
            step(1'b1, 1'b0, 1'b0, a, 8'h00, s);
        end
        chk("load_accept_bound", s, 0);
    endtask

    initial begin
        logic       s;
        logic       rd, wr, fl;
        logic [7:0] a, d;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        exp_rdata     = 8'h00;
        exp_valid     = 1'b0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        do_reset();

        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h5A, s);
        load_hold(8'h10);
        chk("st_ld_first", bus.rdata, 8'h5A);
        load_hold(8'h10);
        chk("st_ld_second", bus.rdata, 8'h5A);

        step(1'b0, 1'b1, 1'b0, 8'h20, 8'h11, s);
        step(1'b0, 1'b1, 1'b0, 8'h20, 8'h22, s);
        load_hold(8'h20);
        chk("youngest_wins", bus.rdata, 8'h22);

        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'h40 + 8'(k), 8'hA0 + 8'(k), s);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, s);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, s);
        for (int k = 0; k < 5; k++) begin
            load_hold(8'h40 + 8'(k));
            chk("five_stores", bus.rdata, 8'hA0 + 8'(k));
        end

        step(1'b0, 1'b1, 1'b1, 8'h30, 8'h77, s);
        load_hold(8'h30);
        chk("flushed_store", bus.rdata, 8'h00);

        step(1'b1, 1'b1, 1'b0, 8'h60, 8'h66, s);
        chk("rw_read_dropped", bus.rdata_valid, 0);
        load_hold(8'h60);
        chk("rw_store_kept", bus.rdata, 8'h66);

        step(1'b0, 1'b1, 1'b0, 8'h50, 8'h01, s);
        step(1'b0, 1'b1, 1'b0, 8'h51, 8'h02, s);
        step(1'b0, 1'b1, 1'b0, 8'h52, 8'h03, s);
        do_reset();
        load_hold(8'h50);
        chk("rst_drained_50", bus.rdata, 8'h01);
        load_hold(8'h51);
        chk("rst_drained_51", bus.rdata, 8'h02);
        load_hold(8'h52);
        chk("rst_discarded_52", bus.rdata, 8'h00);

        for (int c = 0; c < 800; c++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 7) == 0);
            a  = 8'h80 + 8'($urandom_range(0, 7));
            d  = 8'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(rd, wr, fl, a, d, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
